// File: rtl/axi_rd_arbiter.sv
// Two-to-one AXI4-Lite read arbiter sharing one read master between IFU (port 0) and LSU (port 1).
// Latency: AR accepted in the request cycle, forwarded to the master the next cycle; one transaction in flight.
// Backpressure: slave arready stalls in ADDR, owner rready drives m_rready in RESP; no new AR until R completes.
module axi_rd_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LSU_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [1:0]        s0_rresp,
    output logic [DATA_W-1:0] s0_rdata,

    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [1:0]        s1_rresp,
    output logic [DATA_W-1:0] s1_rdata,

    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [1:0]        m_rresp,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              st_idle;
    logic              st_addr;
    logic              st_resp;
    logic              pick1;
    logic              grant_vld;
    logic              owner_rready;

    assign st_idle = (state_q == ST_IDLE);
    assign st_addr = (state_q == ST_ADDR);
    assign st_resp = (state_q == ST_RESP);

    // Winner selection: fixed LSU priority, or round-robin where a tie goes to the port not granted last.
    always_comb begin
        pick1 = 1'b0;
        if (LSU_PRIO != 0) begin
            pick1 = s1_arvalid;
        end else begin
            pick1 = s1_arvalid & (~s0_arvalid | ~last_grant_q);
        end
    end

    // AR handshake with the winner completes in the same IDLE cycle; suppressed while reset is held.
    always_comb begin
        s0_arready = st_idle & ~reset & s0_arvalid & ~pick1;
        s1_arready = st_idle & ~reset & pick1;
        grant_vld  = s0_arready | s1_arready;
    end

    // Master side: address held from addr_q while in ADDR, R acknowledged by the owner only in RESP.
    always_comb begin
        owner_rready = owner_q ? s1_rready : s0_rready;
        m_arvalid    = st_addr;
        m_araddr     = addr_q;
        m_rready     = st_resp & owner_rready;
    end

    // Response routing: data/resp broadcast, only the owner's rvalid can rise, and only in RESP.
    always_comb begin
        s0_rvalid = st_resp & ~owner_q & m_rvalid;
        s1_rvalid = st_resp &  owner_q & m_rvalid;
        s0_rdata  = m_rdata;
        s1_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s1_rresp  = m_rresp;
        busy      = ~st_idle;
        owner     = owner_q;
    end

    // Next-state logic for the IDLE -> ADDR -> RESP transaction cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    addr_d  = pick1 ? s1_araddr : s0_araddr;
                    owner_d = pick1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Error responses end the transaction exactly like OKAY.
                if (m_rvalid && m_rready) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
        end
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Two-to-one AXI4-Lite read-channel arbiter. It shares the single memory read master between the instruction fetch unit (port 0, IFU) and the load/store unit (port 1, LSU). Each transaction is single-beat and has no ID. The arbiter holds one transaction outstanding at a time and keeps the grant from AR acceptance until the R handshake completes. It sits between the IFU/LSU and the memory/crossbar read port.

Parameters:
ADDR_W, 32, address width of all AR channels
DATA_W, 32, data width of all R channels
LSU_PRIO, 0, 0 = round-robin between ports; 1 = port 1 (LSU) always wins simultaneous requests

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
s0_arvalid  in  1  IFU read address valid
s0_arready  out  1  IFU read address accepted
s0_araddr  in  ADDR_W  IFU read address
s0_rvalid  out  1  IFU read data valid
s0_rready  in  1  IFU read data ready
s0_rresp  out  2  IFU read response
s0_rdata  out  DATA_W  IFU read data
s1_arvalid, s1_arready, s1_araddr, s1_rvalid, s1_rready, s1_rresp, s1_rdata  same as s0_*, for the LSU
m_arvalid  out  1  master read address valid
m_arready  in  1  slave accepts address
m_araddr  out  ADDR_W  master read address
m_rvalid  in  1  slave read data valid
m_rready  out  1  master read data ready
m_rresp  in  2  slave read response
m_rdata  in  DATA_W  slave read data
busy  out  1  a transaction is in flight (state != IDLE)
owner  out  1  granted port; valid only while busy

Behaviour:
- Reset values: state = IDLE, owner = 0, last_grant = 1 (so port 0 wins the first tie), addr_q = 0. All outputs are 0 at reset: s*_arready, s*_rvalid, m_arvalid, m_rready, busy.
- FSM has three states: IDLE, ADDR, RESP.
- IDLE:
  - If any s*_arvalid is high, pick a winner.
  - With LSU_PRIO=1, port 1 wins if s1_arvalid is high.
  - Otherwise (round-robin), a lone requester wins; on a tie the port != last_grant wins.
  - The winner's s_arready is driven high combinationally in the same cycle, so its AR handshake completes that cycle.
  - On that handshake: addr_q <= winner araddr, owner <= winner, state <= ADDR.
  - The loser's arready stays 0; its request stays pending.
- ADDR:
  - m_arvalid = 1 and m_araddr = addr_q, both held stable until m_arready.
  - On m_arvalid && m_arready, state <= RESP.
  - Minimum latency: slave arvalid at cycle N, m_arvalid at cycle N+1.
- RESP:
  - m_rready = rready of the owner.
  - Owner rvalid = m_rvalid; owner rresp and rdata are forwarded combinationally.
  - Non-owner rvalid = 0. rdata/rresp may be broadcast to both ports but are only qualified by rvalid.
  - On m_rvalid && m_rready: last_grant <= owner, state <= IDLE.
  - rresp errors (SLVERR/DECERR) are passed through unchanged and end the transaction normally.
- Both s*_arready are 0 in ADDR and RESP: no new AR is accepted until the current R completes.
- The next grant is possible in the cycle after the R handshake (IDLE cycle). Back-to-back transactions therefore cost at least 3 cycles each with a zero-wait slave.
- Outside RESP, m_rready = 0 and a stray m_rvalid is neither forwarded nor acknowledged.
- Reset asserted mid-transaction returns the FSM to IDLE next edge and deasserts m_arvalid/m_rready. Any late response from the slave is ignored per the rule above.
- A requester deasserting arvalid before its grant is legal and simply drops out of arbitration.
- m_araddr = addr_q in all states; it is only meaningful while m_arvalid is high.

Test Plan:
- Single IFU read: s0_araddr=0x80000000 with m_arready=1, rdata=0x00000413 one cycle later. Expect s0_arready in the request cycle, m_arvalid/m_araddr=0x80000000 the next cycle, s0_rvalid with rdata=0x00000413, s1_rvalid never high.
- Simultaneous request after reset, LSU_PRIO=0: s0=0x80000004, s1=0x80001000. Expect port 0 served first, then port 1, then a renewed tie goes to port 0 (alternation).
- Same tie with LSU_PRIO=1: port 1 is granted every time both request; port 0 is served only when s1_arvalid is low.
- Slave backpressure: m_arready low for 4 cycles, then the R phase with s1_rready low for 2 cycles. Expect m_araddr stable throughout, m_rready mirroring s1_rready, and no new grant until the handshake.
- Error response: m_rresp=2'b10 on an LSU read. Expect s1_rresp=2'b10, the FSM back to IDLE, and the next IFU read served normally.
- Reset in RESP state with the slave asserting m_rvalid after reset releases. Expect m_arvalid=0, busy=0, no s*_rvalid pulse, and a fresh request arbitrated with port 0 winning the tie.
